// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Two-stage RV32I instruction encoder. Captures a decoded field
//             bundle, range/alignment checks the immediate for the opcode's
//             format, scatters it into instruction bit positions and writes
//             the word to instruction memory at an auto-incrementing address.
//  Ports    : clk, rst, clear        - clock, sync active-high reset / clear
//             in_valid / in_ready    - field bundle handshake
//             in_opcode..in_imm      - decoded fields, sign-extended immediate
//             mem_we/mem_ready       - write request / memory accept
//             mem_addr, mem_wdata    - word address, encoded instruction
//             err_valid, err_code    - one-cycle reject pulse and reason
//             full                   - last address has been written
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              err_valid,
   output logic [1:0]        err_code,
   output logic              full
);

   localparam logic [6:0] c_OP_R      = 7'b0110011;
   localparam logic [6:0] c_OP_ARITHI = 7'b0010011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;

   localparam logic [1:0] c_ERR_NONE  = 2'd0;
   localparam logic [1:0] c_ERR_RANGE = 2'd1;
   localparam logic [1:0] c_ERR_ALIGN = 2'd2;
   localparam logic [1:0] c_ERR_OPC   = 2'd3;

   localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] c_LAST = '1;

   // S1 capture register
   logic              v1_q, v1_d;
   logic [6:0]        op_q;
   logic [4:0]        rd_q, rs1_q, rs2_q;
   logic [2:0]        f3_q;
   logic [6:0]        f7_q;
   logic [31:0]       imm_q;

   // S2 output registers
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              errv_q, errv_d;
   logic [1:0]        errc_q, errc_d;
   logic              full_q, full_d;

   logic              w_s2_adv;
   logic              w_wr_done;
   logic              w_last_done;
   logic              w_s2_go;
   logic              w_hs;
   logic              w_fit12, w_fit13, w_fit21;
   logic [31:0]       w_word;
   logic [1:0]        w_err_code;

   // Sign-extension checks: all upper bits equal means the value fits.
   assign w_fit12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
   assign w_fit13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
   assign w_fit21 = (&imm_q[31:20]) | ~(|imm_q[31:20]);

   assign w_s2_adv    = ~we_q | mem_ready;
   assign w_wr_done   = we_q & mem_ready;
   assign w_last_done = w_wr_done & (addr_q == c_LAST);
   // Once the final address is consumed, anything still in S1 is discarded
   // silently: no write, no error.
   assign w_s2_go     = v1_q & w_s2_adv & ~full_q & ~w_last_done;

   assign in_ready = ~full_q & (~v1_q | w_s2_adv) & ~rst & ~clear;
   assign w_hs     = in_valid & in_ready;

   always_comb begin
      w_word     = 32'd0;
      w_err_code = c_ERR_NONE;
      case (op_q)
         c_OP_R: begin
            w_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
         end
         c_OP_ARITHI, c_OP_LOAD, c_OP_JALR: begin
            w_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
            if (!w_fit12) w_err_code = c_ERR_RANGE;
         end
         c_OP_STORE: begin
            w_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
            if (!w_fit12) w_err_code = c_ERR_RANGE;
         end
         c_OP_BRANCH: begin
            w_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                      imm_q[4:1], imm_q[11], op_q};
            if (imm_q[0])      w_err_code = c_ERR_ALIGN;
            else if (!w_fit13) w_err_code = c_ERR_RANGE;
         end
         c_OP_LUI, c_OP_AUIPC: begin
            w_word = {imm_q[31:12], rd_q, op_q};
            if (|imm_q[11:0]) w_err_code = c_ERR_RANGE;
         end
         c_OP_JAL: begin
            w_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                      rd_q, op_q};
            if (imm_q[0])      w_err_code = c_ERR_ALIGN;
            else if (!w_fit21) w_err_code = c_ERR_RANGE;
         end
         default: begin
            w_err_code = c_ERR_OPC;
         end
      endcase
   end

   always_comb begin
      v1_d    = v1_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      errv_d  = 1'b0;
      errc_d  = c_ERR_NONE;
      full_d  = full_q;

      if (w_hs)
         v1_d = 1'b1;
      else if (w_s2_adv || full_q)
         v1_d = 1'b0;

      // mem_we/mem_wdata only change when S2 may advance, so they hold
      // steady through a memory stall.
      if (w_s2_adv)
         we_d = w_s2_go & (w_err_code == c_ERR_NONE);
      if (w_s2_go && (w_err_code == c_ERR_NONE))
         wdata_d = w_word;
      if (w_s2_go && (w_err_code != c_ERR_NONE)) begin
         errv_d = 1'b1;
         errc_d = w_err_code;
      end

      if (w_wr_done) begin
         if (addr_q == c_LAST) full_d = 1'b1;
         else                  addr_d = addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         v1_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= c_BASE;
         wdata_q <= 32'd0;
         errv_q  <= 1'b0;
         errc_q  <= c_ERR_NONE;
         full_q  <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         errv_q  <= errv_d;
         errc_q  <= errc_d;
         full_q  <= full_d;
      end
   end

   // Field payload is qualified by v1_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_hs) begin
         op_q  <= in_opcode;
         rd_q  <= in_rd;
         rs1_q <= in_rs1;
         rs2_q <= in_rs2;
         f3_q  <= in_funct3;
         f7_q  <= in_funct7;
         imm_q <= in_imm;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign err_valid = errv_q;
   assign err_code  = errc_q;
   assign full      = full_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking bench for instr_encoder. A transaction-level
//             reference model predicts, per accepted bundle, either an encoded
//             word or an error code; a negedge monitor compares the DUT
//             against it every cycle. Directed cases pin literal encodings.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

   typedef struct {
      logic [1:0]  code;
      logic [31:0] word;
   } exp_t;

   logic        clk;
   logic        rst, clear, in_valid, in_ready;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm;
   logic        mem_we, mem_ready, err_valid, full;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  err_code;

   logic        s_clear, s_in_valid, s_in_ready, s_mem_we, s_mem_ready;
   logic        s_err_valid, s_full;
   logic [1:0]  s_mem_addr, s_err_code;
   logic [31:0] s_mem_wdata;

   int checks = 0;
   int errors = 0;

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .err_valid(err_valid), .err_code(err_code),
      .full(full)
   );

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
      .clk(clk), .rst(rst), .clear(s_clear),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .mem_we(s_mem_we), .mem_ready(s_mem_ready), .mem_addr(s_mem_addr),
      .mem_wdata(s_mem_wdata), .err_valid(s_err_valid), .err_code(s_err_code),
      .full(s_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, got, req);
      end
   endtask

   // Reference model: outcome of one bundle from the format rules, using
   // signed ranges and shift/mask arithmetic.
   function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] imm);
      exp_t e;
      int   s;
      logic [31:0] regs;
      s      = $signed(imm);
      e.code = 2'd0;
      e.word = 32'd0;
      regs   = (32'(rs1) << 15) | (32'(f3) << 12);
      case (op)
         7'h33: e.word = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'(op);
         7'h13, 7'h03, 7'h67: begin
            if (s < -2048 || s > 2047) e.code = 2'd1;
            e.word = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'(op);
         end
         7'h23: begin
            if (s < -2048 || s > 2047) e.code = 2'd1;
            e.word = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
                     | ((imm & 32'h1F) << 7) | 32'(op);
         end
         7'h63: begin
            if (imm % 2 != 0)               e.code = 2'd2;
            else if (s < -4096 || s > 4095) e.code = 2'd1;
            e.word = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (32'(rs2) << 20) | regs | (((imm >> 1) & 32'hF) << 8)
                     | (((imm >> 11) & 1) << 7) | 32'(op);
         end
         7'h37, 7'h17: begin
            if (imm % 4096 != 0) e.code = 2'd1;
            e.word = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
         end
         7'h6F: begin
            if (imm % 2 != 0)                          e.code = 2'd2;
            else if (s < -1048576 || s > 1048575)      e.code = 2'd1;
            e.word = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                     | (32'(rd) << 7) | 32'(op);
         end
         default: e.code = 2'd3;
      endcase
      return e;
   endfunction

   // ---------------- monitor / scoreboard for the main instance ----------
   exp_t        exp_q[$];
   logic [31:0] wlog_word[$];
   logic [7:0]  wlog_addr[$];
   int          wlog_t[$];
   logic [1:0]  elog[$];
   bit          armed = 0, post_rst = 0, prev_stall = 0, full_pend = 0, model_full = 0;
   logic [7:0]  model_addr = 8'd0;
   logic [7:0]  p_addr;
   logic [31:0] p_wdata;
   int          cyc = 0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) armed = 1;
      if (armed) begin
         if (rst || clear) begin
            chk("ready_during_reset", in_ready, 0);
            exp_q.delete();
            model_addr = 8'd0; model_full = 0; full_pend = 0;
            prev_stall = 0; post_rst = 1;
         end else begin
            if (post_rst) begin
               chk("rst_mem_we", mem_we, 0);
               chk("rst_mem_wdata", mem_wdata, 0);
               chk("rst_err_valid", err_valid, 0);
               chk("rst_err_code", err_code, 0);
               chk("rst_full", full, 0);
               post_rst = 0;
            end
            if (full_pend) begin
               model_full = 1; full_pend = 0; exp_q.delete();
            end
            if (prev_stall) begin
               chk("stall_we_held", mem_we, 1);
               chk("stall_addr_held", mem_addr, p_addr);
               chk("stall_data_held", mem_wdata, p_wdata);
            end
            chk("full", full, model_full);
            chk("mem_addr", mem_addr, model_addr);
            if (model_full) begin
               chk("ready_when_full", in_ready, 0);
               chk("we_when_full", mem_we, 0);
            end else if (!mem_we) begin
               chk("ready_when_s2_free", in_ready, 1);
            end
            if (err_valid) begin
               elog.push_back(err_code);
               chk("err_has_pending", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("err_code", err_code, e.code);
               end
            end
            if (mem_we && mem_ready) begin
               wlog_word.push_back(mem_wdata);
               wlog_addr.push_back(mem_addr);
               wlog_t.push_back(cyc);
               chk("wr_has_pending", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("wr_expected_code", 0, e.code);
                  chk("wr_data", mem_wdata, e.word);
               end
               if (model_addr == 8'hFF) full_pend = 1;
               else                     model_addr = model_addr + 8'd1;
            end
            prev_stall = mem_we && !mem_ready;
            p_addr     = mem_addr;
            p_wdata    = mem_wdata;
            if (in_valid && in_ready)
               exp_q.push_back(model(in_opcode, in_rd, in_rs1, in_rs2,
                                     in_funct3, in_funct7, in_imm));
         end
      end
   end

   // ---------------- stimulus helpers (called at posedge+1) --------------
   task automatic set_fields(input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [2:0] f3, input logic [31:0] imm);
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = 7'd0; in_imm = imm;
   endtask

   task automatic wait_accept(input string name);
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk({name, "_accept_timeout"}, 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [31:0] imm);
      set_fields(op, rd, rs1, rs2, f3, imm);
      in_valid = 1'b1;
      wait_accept("send");
   endtask

   task automatic settle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      in_valid = 1'b0;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      wlog_word.delete(); wlog_addr.delete(); wlog_t.delete(); elog.delete();
   endtask

   task automatic rand_fields();
      logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      logic [31:0] imm;
      in_opcode = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      case ($urandom_range(0, 4))
         0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
         1:       imm = $urandom;
         2:       imm = $urandom & 32'hFFFFF000;
         3:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      if ($urandom_range(0, 2) != 0) imm = imm & ~32'd1;
      in_imm = imm;
   endtask

   // ---------------- test sequence ---------------------------------------
   initial begin
      exp_t m;
      int   acc, wr;
      bit   got_full;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
      s_clear = 1'b0; s_in_valid = 1'b0; s_mem_ready = 1'b1;
      set_fields(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Model pins against hand-computed encodings.
      m = model(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      chk("model_addi", m.word, 32'h00500093);
      m = model(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
      chk("model_branch", m.word, 32'hFE000EE3);
      m = model(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000);
      chk("model_jal_range", m.code, 2'd1);

      // Arith_I with 2-edge latency.
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_we_after_1_edge", mem_we, 0);
      @(negedge clk);
      chk("lat_we_after_2_edges", mem_we, 1);
      chk("addi_word", mem_wdata, 32'h00500093);
      chk("addi_addr", mem_addr, 0);
      @(posedge clk); #1;

      // Store then Branch, back-to-back.
      do_clear();
      send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
      send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC);
      settle(6);
      chk("b2b_count", wlog_word.size(), 2);
      if (wlog_word.size() == 2) begin
         chk("store_word", wlog_word[0], 32'h0020A423);
         chk("store_addr", wlog_addr[0], 0);
         chk("branch_word", wlog_word[1], 32'hFE000EE3);
         chk("branch_addr", wlog_addr[1], 1);
         chk("b2b_consecutive", wlog_t[1] - wlog_t[0], 1);
      end

      // LUI good, LUI misfit, then a word reusing the address.
      do_clear();
      send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
      send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345001);
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
      settle(6);
      chk("lui_writes", wlog_word.size(), 2);
      chk("lui_errs", elog.size(), 1);
      if (wlog_word.size() == 2 && elog.size() == 1) begin
         chk("lui_word", wlog_word[0], 32'h123452B7);
         chk("lui_addr", wlog_addr[0], 0);
         chk("lui_err_code", elog[0], 1);
         chk("after_err_word", wlog_word[1], 32'h00500093);
         chk("after_err_addr", wlog_addr[1], 1);
      end

      // JAL range / alignment / unsupported opcode, and a legal JAL.
      do_clear();
      send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00100000);
      send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
      send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
      send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
      settle(6);
      chk("err_pulses", elog.size(), 3);
      if (elog.size() == 3) begin
         chk("jal_range_code", elog[0], 1);
         chk("jal_align_code", elog[1], 2);
         chk("bad_opcode_code", elog[2], 3);
      end
      chk("jal_ok_writes", wlog_word.size(), 1);
      if (wlog_word.size() == 1) chk("jal_ok_word", wlog_word[0], 32'h001000EF);

      // Memory stall with three bundles offered.
      do_clear();
      mem_ready = 1'b0;
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
      set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_mem_we", mem_we, 1);
      end
      @(posedge clk); #1;
      mem_ready = 1'b1;
      wait_accept("stall");
      settle(6);
      chk("stall_writes", wlog_word.size(), 3);
      if (wlog_word.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("stall_order_word", wlog_word[i], 32'h00000093 | (32'(i + 1) << 20));
            chk("stall_order_addr", wlog_addr[i], 32'(i));
         end
      end

      // Reset in the middle of a stall: the stalled word is lost.
      do_clear();
      mem_ready = 1'b0;
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd7);
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd9);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mem_ready = 1'b1;
      settle(6);
      chk("rst_stall_writes", wlog_word.size(), 0);
      chk("rst_stall_errs", elog.size(), 0);

      // ADDR_W=2 instance: fills after 4 writes, then refuses input.
      acc = 0; wr = 0; got_full = 0;
      set_fields(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd4);
      s_in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (s_mem_we && s_mem_ready) begin
            chk("small_addr", s_mem_addr, 32'(wr));
            chk("small_not_full_yet", s_full, 0);
            wr++;
         end
         if (s_in_valid && s_in_ready) acc++;
         @(posedge clk); #1;
         if (acc == 4) s_in_valid = 1'b0;
         if (s_full) begin got_full = 1; break; end
      end
      chk("small_full_reached", got_full, 1);
      chk("small_write_count", wr, 4);
      s_in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("small_full", s_full, 1);
         chk("small_ready_full", s_in_ready, 0);
         chk("small_we_full", s_mem_we, 0);
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      s_clear = 1'b1;
      @(posedge clk); #1;
      s_clear = 1'b0;
      @(negedge clk);
      chk("small_clear_full", s_full, 0);
      chk("small_clear_addr", s_mem_addr, 0);
      chk("small_clear_ready", s_in_ready, 1);
      @(posedge clk); #1;

      // Randomized traffic against the scoreboard.
      for (int i = 0; i < 1500; i++) begin
         rand_fields();
         in_valid  = ($urandom_range(0, 9) < 7);
         mem_ready = ($urandom_range(0, 3) != 0);
         clear     = (i % 300 == 299);
         @(posedge clk); #1;
      end
      clear = 1'b0;
      mem_ready = 1'b1;
      settle(8);
      chk("drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V RV32I instruction encoder. It is the inverse of the datapath's immediate generator: it takes decoded fields (opcode, registers, funct, full 32-bit immediate), range-checks the immediate for the opcode's format, scatters it into the instruction bit positions, and writes the word into instruction memory at an auto-incrementing address. It sits in the test/boot infrastructure and fills the instruction ROM/RAM that the datapath's fetch stage reads.

## Interface

Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- BASE_ADDR, 0: first word address written after reset or clear.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: reset. One clock; reset is synchronous and active-high.
- clear, input, 1: synchronous; same effect as rst on all state.
- in_valid, input, 1: field bundle valid.
- in_ready, output, 1: encoder can accept.
- in_opcode, input, 7: opcode.
- in_rd / in_rs1 / in_rs2, input, 5 each: register fields.
- in_funct3, input, 3: funct3 field.
- in_funct7, input, 7: funct7 field; R-type only.
- in_imm, input, 32: immediate as the datapath sees it after sign extension.
- mem_we, output, 1: write request.
- mem_ready, input, 1: memory accepts the write this cycle.
- mem_addr, output, ADDR_W: word address.
- mem_wdata, output, 32: encoded instruction.
- err_valid, output, 1: one-cycle pulse for a rejected bundle.
- err_code, output, 2: 1 = immediate out of range, 2 = misaligned (bit 0 set for Branch/JAL), 3 = unsupported opcode.
- full, output, 1: the last address has been written.

## Operation

- Opcodes supported:
  - 0110011 R: {f7, rs2, rs1, f3, rd, op}.
  - 0010011 Arith_I, 0000011 Load, 1100111 JALR, I: {imm[11:0], rs1, f3, rd, op}.
  - 0100011 Store, S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - 1100011 Branch, B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - 0110111 LUI and 0010111 AUIPC, U: {imm[31:12], rd, op}.
  - 1101111 JAL, J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Range checks:
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal.
  - J: imm[31:20] all equal.
  - U: imm[11:0] == 0, else code 1.
  - R: imm is ignored.
- Alignment: B and J require imm[0] == 0.
- Error priority: code 3 > 2 > 1.
- Pipeline:
  - S1 is a capture register (v1) loaded on the in_valid && in_ready handshake.
  - S2 encodes and checks S1, then either loads the output register (mem_we=1) or pulses err_valid for one cycle.
- Errored bundles are dropped: no write, address unchanged.
- Stall: while mem_we && !mem_ready, mem_addr, mem_wdata and mem_we hold stable. S1 holds and in_ready = !v1.
- in_ready = !full && (!v1 || S2 can advance). S2 advances when !mem_we || mem_ready.
- Address counter:
  - Increments by 1 on each completed write (mem_we && mem_ready).
  - When the write at address 2^ADDR_W−1 completes, full sets and the counter does not wrap.
  - full forces in_ready=0 until rst/clear. Bundles already in the pipeline at that point are discarded with no write and no error.
- Reset values, rst or clear:
  - in_ready=0 during the reset cycle, 1 afterwards.
  - mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR, err_valid=0, err_code=0, full=0, v1=0.
  - Any in-flight bundle is lost.
- Simultaneous handshake and S2 advance in one cycle is legal, giving one word per cycle throughput.

## Timing

- Handshake at edge k → S1 valid after k → mem_we (or err_valid) asserted after edge k+1. Latency is 2 edges.
- A write completes at the first edge where mem_we && mem_ready. mem_addr updates after that edge.
- err_valid is high for exactly one cycle per rejected bundle; err_code is valid only with err_valid.
- full asserts the cycle after the final write completes.
- With mem_ready tied high, back-to-back input gives back-to-back writes at consecutive addresses.

## Test plan

- Arith_I op=0010011, rd=1, rs1=0, f3=0, imm=5 → mem_wdata=0x00500093 at addr 0, 2 edges after handshake.
- Store f3=010, rs1=1, rs2=2, imm=8, then Branch f3=0, rs1=rs2=0, imm=0xFFFFFFFC back-to-back with mem_ready=1 → 0x0020A423 at addr 0, 0xFE000EE3 at addr 1 on consecutive cycles.
- LUI rd=5, imm=0x12345000 → 0x123452B7. Same with imm=0x12345001 → err_valid, code 1, no write, next word reuses the same address.
- JAL imm=0x00100000 → code 1. JAL imm=3 → code 2. Opcode 1111111 → code 3. Each gives a single-cycle pulse.
- Hold mem_ready=0 for 5 cycles with 3 bundles offered → mem_* stable, in_ready low once S1 is filled, all 3 words written in order after release.
- ADDR_W=2: write 4 words → full=1 after the 4th, in_ready=0. A 5th bundle is never accepted. clear → full=0, mem_addr=0.
- Assert rst mid-stall → next cycle all outputs at their reset values, and the stalled word is never written.
